sync_fifo: RTL and testbench
============================

// Module: sync_fifo
// PURPOSE
//   Single-clock first-in/first-out buffer of Depth words x DataWidth bits.
//   Decouples a producer and a consumer in the same clock domain (e.g. command/data staging
//   around the SDRAM controller). First-word-fall-through read: head word always visible on o_rd_data.
// PARAMETERS
//   DataWidth  8  width of each stored word in bits
//   Depth      8  number of storage entries; must be a power of two >= 2
// PORTS
//   i_clk      in   1          single clock; all state updates on rising edge
//   i_rst      in   1          synchronous reset, active-high
//   i_wr_data  in   DataWidth  word to enqueue
//   i_wr_en    in   1          write request, sampled on rising i_clk
//   i_rd_en    in   1          read (pop) request, sampled on rising i_clk
//   o_rd_data  out  DataWidth  current head word (valid while o_empty==0)
//   o_full     out  1          FIFO holds Depth words
//   o_empty    out  1          FIFO holds 0 words
//   o_overflow out  1          sticky write-when-full flag (only with SYNC_FIFO_ERR_FLAGS_EN)
//   o_underflow out 1          sticky read-when-empty flag (only with SYNC_FIFO_ERR_FLAGS_EN)
// BEHAVIOUR
//   - Storage: Depth-entry register array; write and read pointers of $clog2(Depth)+1 bits
//     (extra MSB distinguishes full from empty); index = pointer low bits, wraps naturally.
//   - Reset (i_rst=1 at rising edge): both pointers <= 0; o_empty=1, o_full=0; error flags 0.
//     Array contents not cleared. Reset has priority over any concurrent read/write.
//   - Write accepted iff i_wr_en=1 and o_full=0: mem[wr_ptr] <= i_wr_data, wr_ptr++.
//     Write while full is dropped; contents and pointers unchanged.
//   - Read accepted iff i_rd_en=1 and o_empty=0: rd_ptr++. Read while empty is ignored.
//   - o_rd_data = mem[rd_ptr] combinationally (zero read latency); value undefined/don't-care
//     while o_empty=1. After an accepted read, next head appears after that same edge.
//   - Flags combinational from pointers: o_empty = (wr_ptr==rd_ptr);
//     o_full = (MSBs differ && low bits equal). Both update the cycle after the causing edge.
//   - Write into empty FIFO: o_empty drops and o_rd_data shows the word after that edge.
//   - Simultaneous read+write: each judged against flags before the edge; when neither flag
//     set both happen and occupancy is unchanged; when full only the read happens; when empty
//     only the write happens.
//   - Depth writes from empty with no reads -> o_full=1; data read back in write order.
// CONFIGURATION
//   SYNC_FIFO_ERR_FLAGS_EN defined: adds o_overflow/o_underflow; o_overflow sets on rising
//     edge with i_wr_en=1 and o_full=1, o_underflow on i_rd_en=1 and o_empty=1; both hold
//     until i_rst. Dropped-access behaviour unchanged.
//   Not defined: ports and logic absent; dropped accesses are silent.
// TESTING
//   1. Hold i_rst=1 two cycles, release -> o_empty=1, o_full=0; repeat reset mid-fill -> empty again.
//   2. Write 8 words 0x24,0x81,0x09,0x63,0x0D,0x8D,0x65,0x12 -> o_full=1 after 8th edge, o_empty=0.
//   3. With full, 9th write 0x01 -> dropped; then 8 pops -> o_rd_data sequence exactly as written
//      (0x24 first), 0x01 never appears, o_empty=1 after 8th pop.
//   4. From 4 stored words, 6 cycles of concurrent write+read -> occupancy stays 4, order preserved
//      across pointer wrap.
//   5. Read on empty / write on full -> pointers unchanged; with SYNC_FIFO_ERR_FLAGS_EN,
//      o_underflow / o_overflow go 1 and stay 1 until i_rst.

Source files
------------

// File: rtl/sync_fifo.sv
// Single-clock FWFT FIFO, Depth x DataWidth, decoupling producer and consumer in one clock domain.
// Latency: a written word is visible on o_rd_data the cycle after its write edge; reads are zero-latency.
// Backpressure: producer must respect o_full, consumer o_empty; ignored requests are dropped (optional sticky error flags).
//
// Optional feature macro: SYNC_FIFO_ERR_FLAGS_EN adds the sticky o_overflow / o_underflow outputs.

module sync_fifo #(
    parameter int DataWidth = 8,
    parameter int Depth     = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [DataWidth-1:0] i_wr_data,
    input  logic                 i_wr_en,
    input  logic                 i_rd_en,
    output logic [DataWidth-1:0] o_rd_data,
    output logic                 o_full,
    output logic                 o_empty
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    ,
    output logic                 o_overflow,
    output logic                 o_underflow
`endif
);

    // Pointers carry one extra MSB so that equal low bits can mean either empty or full.
    localparam int AddrW = $clog2(Depth);
    localparam int PtrW  = AddrW + 1;

    logic [DataWidth-1:0] mem [Depth];
    logic [PtrW-1:0]      wr_ptr;
    logic [PtrW-1:0]      rd_ptr;
    logic [AddrW-1:0]     wr_idx;
    logic [AddrW-1:0]     rd_idx;
    logic                 wr_accept;
    logic                 rd_accept;

    assign wr_idx = wr_ptr[AddrW-1:0];
    assign rd_idx = rd_ptr[AddrW-1:0];

    // Status flags derived purely from the pointers; each request is judged against these pre-edge values.
    always_comb begin
        o_empty   = (wr_ptr == rd_ptr);
        o_full    = (wr_ptr[AddrW] != rd_ptr[AddrW]) && (wr_idx == rd_idx);
        wr_accept = i_wr_en && !o_full;
        rd_accept = i_rd_en && !o_empty;
    end

    // First-word-fall-through: the head entry is driven straight out of the array.
    assign o_rd_data = mem[rd_idx];

    // Pointer update; reset wins over any concurrent access.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + PtrW'(1);
            end
            if (rd_accept) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end
        end
    end

    // Storage write; contents are left alone by reset, and a write coinciding with reset is discarded.
    always_ff @(posedge i_clk) begin
        if (!i_rst && wr_accept) begin
            mem[wr_idx] <= i_wr_data;
        end
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    // Sticky error flags: set on a refused request, cleared only by reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (i_wr_en && o_full) begin
                o_overflow <= 1'b1;
            end
            if (i_rd_en && o_empty) begin
                o_underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: directed vector table, hand-written corner sequences, then random traffic vs a queue model.
// Inputs are driven 1 time unit after a rising edge; outputs are sampled there too, reflecting that edge.
// Works with or without SYNC_FIFO_ERR_FLAGS_EN; flag checks are compiled in only when the ports exist.

module tb_sync_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic [DW-1:0] rd_data;
    logic          full;
    logic          empty;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic          ovf;
    logic          udf;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sync_fifo #(.DataWidth(DW), .Depth(DEPTH)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_wr_data  (wr_data),
        .i_wr_en    (wr_en),
        .i_rd_en    (rd_en),
        .o_rd_data  (rd_data),
        .o_full     (full),
        .o_empty    (empty)
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        ,
        .o_overflow (ovf),
        .o_underflow(udf)
`endif
    );

    typedef struct packed {
        logic          rst;
        logic          wr;
        logic          rd;
        logic [DW-1:0] din;
        logic          e_empty;
        logic          e_full;
        logic          chk_data;
        logic [DW-1:0] e_data;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic w, input logic rd, input logic [DW-1:0] d,
                                input logic ee, input logic ef, input logic cd, input logic [DW-1:0] ed);
        vec_t v;
        v.rst = r; v.wr = w; v.rd = rd; v.din = d;
        v.e_empty = ee; v.e_full = ef; v.chk_data = cd; v.e_data = ed;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One clock: apply inputs, let the edge happen, settle just after it.
    task automatic drive(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
        rst = r; wr_en = w; rd_en = rd; wr_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input logic ee, input logic ef, input logic cd,
                               input logic [DW-1:0] ed);
        check({tag, "_empty"}, 32'(empty), 32'(ee));
        check({tag, "_full"}, 32'(full), 32'(ef));
        if (cd) check({tag, "_data"}, 32'(rd_data), 32'(ed));
    endtask

    initial begin
        logic [DW-1:0] w[8];
        logic [DW-1:0] a[10];
        logic [DW-1:0] mq[$];
        logic          m_ovf;
        logic          m_udf;
        w = '{8'h24, 8'h81, 8'h09, 8'h63, 8'h0D, 8'h8D, 8'h65, 8'h12};

        // ---------------- directed vector table ----------------
        vecs.push_back(mk(1, 0, 0, 8'h00, 1, 0, 0, 8'h00));
        vecs.push_back(mk(1, 0, 0, 8'h00, 1, 0, 0, 8'h00));
        vecs.push_back(mk(0, 0, 0, 8'h00, 1, 0, 0, 8'h00));
        for (int i = 0; i < 8; i++)
            vecs.push_back(mk(0, 1, 0, w[i], 0, (i == 7), 1, 8'h24));
        vecs.push_back(mk(0, 1, 0, 8'h01, 0, 1, 1, 8'h24));          // write while full: dropped
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(0, 0, 1, 8'h00, (k == 7), 0, (k != 7), (k < 7) ? w[k+1] : 8'h00));
        vecs.push_back(mk(0, 1, 1, 8'h5A, 0, 0, 1, 8'h5A));          // wr+rd on empty: only write
        vecs.push_back(mk(0, 1, 0, 8'h11, 0, 0, 1, 8'h5A));
        vecs.push_back(mk(1, 1, 0, 8'h33, 1, 0, 0, 8'h00));          // reset mid-fill beats write
        vecs.push_back(mk(0, 0, 1, 8'h00, 1, 0, 0, 8'h00));          // read on empty: ignored
        vecs.push_back(mk(0, 1, 0, 8'h77, 0, 0, 1, 8'h77));          // head is the new word

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].din);
            check_state($sformatf("vec%0d", i), vecs[i].e_empty, vecs[i].e_full,
                        vecs[i].chk_data, vecs[i].e_data);
        end

        // ---------------- concurrent read+write across pointer wrap ----------------
        drive(1, 0, 0, 8'h00);
        for (int i = 0; i < 10; i++) a[i] = 8'(8'hA0 + i);
        for (int i = 0; i < 4; i++) drive(0, 1, 0, a[i]);
        check_state("wrap_fill", 0, 0, 1, a[0]);
        for (int k = 1; k <= 6; k++) begin
            drive(0, 1, 1, a[k+3]);
            check_state($sformatf("wrap_rw%0d", k), 0, 0, 1, a[k]);
        end
        for (int k = 7; k <= 10; k++) begin
            drive(0, 0, 1, 8'h00);
            check_state($sformatf("wrap_drain%0d", k), (k == 10), 0, (k != 10), (k < 10) ? a[k] : 8'h00);
        end

        // ---------------- concurrent read+write while full: only the read happens ----------------
        for (int i = 0; i < 8; i++) drive(0, 1, 0, 8'(i * 3 + 1));
        check_state("full_fill", 0, 1, 1, 8'h01);
        drive(0, 1, 1, 8'hEE);
        check_state("full_rw", 0, 0, 1, 8'h04);
        for (int i = 2; i <= 8; i++) begin
            drive(0, 0, 1, 8'h00);
            check_state($sformatf("full_drain%0d", i), (i == 8), 0, (i != 8), 8'(i * 3 + 1));
        end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
        // ---------------- sticky error flags ----------------
        drive(1, 0, 0, 8'h00);
        check("flag_rst_ovf", 32'(ovf), 32'(0));
        check("flag_rst_udf", 32'(udf), 32'(0));
        drive(0, 0, 1, 8'h00);
        check("flag_udf_set", 32'(udf), 32'(1));
        check("flag_ovf_clear", 32'(ovf), 32'(0));
        for (int i = 0; i < 8; i++) drive(0, 1, 0, 8'(i));
        check("flag_udf_hold", 32'(udf), 32'(1));
        check("flag_ovf_pre", 32'(ovf), 32'(0));
        drive(0, 1, 0, 8'hFF);
        check("flag_ovf_set", 32'(ovf), 32'(1));
        drive(0, 0, 1, 8'h00);
        check("flag_ovf_hold", 32'(ovf), 32'(1));
        check_state("flag_data", 0, 0, 1, 8'h01);
        drive(1, 0, 0, 8'h00);
        check("flag_ovf_rst", 32'(ovf), 32'(0));
        check("flag_udf_rst", 32'(udf), 32'(0));
`endif

        // ---------------- random traffic vs queue model ----------------
        drive(1, 0, 0, 8'h00);
        mq.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            logic          r, wr, rd;
            logic [DW-1:0] d;
            bit            fill_phase;
            fill_phase = ((n / 150) % 2) == 0;
            r  = ($urandom_range(0, 399) == 0);
            wr = fill_phase ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            rd = fill_phase ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            d  = 8'($urandom);
            // Model: judge both requests against occupancy before the edge.
            if (r) begin
                mq.delete();
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end else begin
                bit do_w, do_r;
                do_w = wr && (mq.size() < DEPTH);
                do_r = rd && (mq.size() > 0);
                if (wr && mq.size() == DEPTH) m_ovf = 1'b1;
                if (rd && mq.size() == 0) m_udf = 1'b1;
                if (do_r) void'(mq.pop_front());
                if (do_w) mq.push_back(d);
            end
            drive(r, wr, rd, d);
            check($sformatf("rnd%0d_empty", n), 32'(empty), 32'(mq.size() == 0));
            check($sformatf("rnd%0d_full", n), 32'(full), 32'(mq.size() == DEPTH));
            if (mq.size() > 0) check($sformatf("rnd%0d_data", n), 32'(rd_data), 32'(mq[0]));
`ifdef SYNC_FIFO_ERR_FLAGS_EN
            check($sformatf("rnd%0d_ovf", n), 32'(ovf), 32'(m_ovf));
            check($sformatf("rnd%0d_udf", n), 32'(udf), 32'(m_udf));
`endif
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
